// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised 2-read/1-write register file.
// Optional write-through forwarding is selected by the REGFILE_BYPASS_EN macro in the top.
package regfile_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_clear_seq.sv
// Sequenced clear controller: walks the clear index from 0 to DEPTH-1, one
// register per clock, and raises busy for exactly DEPTH cycles.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  clr_state_t      state, state_nx;
  logic [ADDR_W:0] idx, idx_nx, idx_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // The extra index bit marks the write past DEPTH-1, so the sequence ends
  // without ever wrapping back onto register 0.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    idx_inc  = idx + IDX_ONE;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nx = CLEARING;
          idx_nx   = '0;
        end
      end
      CLEARING: begin
        idx_nx = idx_inc;
        if (idx_inc[ADDR_W]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == CLEARING);
    clr_we   = (state == CLEARING);
    clr_addr = idx[ADDR_W-1:0];
  end

endmodule

// File: rtl/registerfile_param_2r1w.sv
// Parametrised register file: two registered read ports, one write port,
// optional hardwired-zero r0, sequenced clear. Macro: REGFILE_BYPASS_EN.
module registerfile_param_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [DATA_W-1:0] in_Cdata,
  input  logic [ADDR_W-1:0] in_Cselect,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_Aselect,
  input  logic              in_Aread,
  output logic [DATA_W-1:0] out_Adata,
  input  logic [ADDR_W-1:0] in_Bselect,
  input  logic              in_Bread,
  output logic [DATA_W-1:0] out_Bdata,
  input  logic              in_clr_start,
  output logic              out_busy,
  output logic              out_wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              busy, clr_we, wr_ok, wr_zero;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] a_rd, b_rd;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk       (in_clk),
    .rst       (in_rst),
    .clr_start (in_clr_start),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign out_busy = busy;

  always_comb begin
    wr_zero = (ZERO_REG != 0) && (in_Cselect == '0);
    wr_ok   = in_write && !busy && !wr_zero;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      // clr_we and wr_ok are mutually exclusive: writes are refused while busy
      if (clr_we) regs[clr_addr] <= '0;
      if (wr_ok)  regs[in_Cselect] <= in_Cdata;
    end
  end

  always_comb begin
    a_rd = regs[in_Aselect];
    b_rd = regs[in_Bselect];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (in_Aselect == in_Cselect)) a_rd = in_Cdata;
    if (wr_ok && (in_Bselect == in_Cselect)) b_rd = in_Cdata;
`endif
    if ((ZERO_REG != 0) && (in_Aselect == '0)) a_rd = '0;
    if ((ZERO_REG != 0) && (in_Bselect == '0)) b_rd = '0;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_Adata   <= '0;
      out_Bdata   <= '0;
      out_wr_drop <= 1'b0;
    end else begin
      if (in_Aread) out_Adata <= a_rd;
      if (in_Bread) out_Bdata <= b_rd;
      out_wr_drop <= in_write && busy;
    end
  end

endmodule

// File: tb/tb_registerfile_param_2r1w.sv
// Self-checking bench: two DUTs (ZERO_REG=1 and ZERO_REG=0) share stimulus;
// a cycle model feeds a scoreboard queue, plus table vectors and clear sequences.
module tb_registerfile_param_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wr, aread, bread, clr;
  logic [31:0] cdata;
  logic [3:0]  csel, asel, bsel;
  logic [31:0] a1, b1, a0, b0;
  logic        busy1, drop1, busy0, drop0;

  always #5 clk = ~clk;

  registerfile_param_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) u_dut (
    .in_clk(clk), .in_rst(rst), .in_Cdata(cdata), .in_Cselect(csel), .in_write(wr),
    .in_Aselect(asel), .in_Aread(aread), .out_Adata(a1),
    .in_Bselect(bsel), .in_Bread(bread), .out_Bdata(b1),
    .in_clr_start(clr), .out_busy(busy1), .out_wr_drop(drop1));

  registerfile_param_2r1w #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) u_dut_nz (
    .in_clk(clk), .in_rst(rst), .in_Cdata(cdata), .in_Cselect(csel), .in_write(wr),
    .in_Aselect(asel), .in_Aread(aread), .out_Adata(a0),
    .in_Bselect(bsel), .in_Bread(bread), .out_Bdata(b0),
    .in_clr_start(clr), .out_busy(busy0), .out_wr_drop(drop0));

  typedef struct {
    logic [31:0] a1, b1, a0, b0;
    logic        busy, drop;
  } exp_t;

  typedef struct {
    logic        w;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        ar;
    logic [3:0]  as;
    logic        br;
    logic [3:0]  bs;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[8];
  logic [31:0] mz[16];
  logic [31:0] mn[16];
  logic [31:0] ha1, hb1, ha0, hb0;
  logic        mbusy;
  int          midx;
  int          errs = 0;
  int          nchk = 0;
  int          nbusy, ndrop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdm(input bit z, input logic [3:0] s, input bit acc,
                                      input logic [3:0] ws, input logic [31:0] wd);
    if (z && s == 4'd0) return 32'h0;
    if (BYP && acc && s == ws) return wd;
    return z ? mz[s] : mn[s];
  endfunction

  task automatic cyc(input bit r, input bit w, input logic [3:0] ws, input logic [31:0] wd,
                     input bit ar, input logic [3:0] as, input bit br, input logic [3:0] bs,
                     input bit c);
    exp_t e, g;
    bit   acc1, acc0;
    rst = r; wr = w; csel = ws; cdata = wd; aread = ar; asel = as;
    bread = br; bsel = bs; clr = c;
    acc1 = w && !mbusy && ws != 4'd0;
    acc0 = w && !mbusy;
    if (r) begin
      e = '{a1: 0, b1: 0, a0: 0, b0: 0, busy: 0, drop: 0};
    end else begin
      e.a1   = ar ? rdm(1'b1, as, acc1, ws, wd) : ha1;
      e.b1   = br ? rdm(1'b1, bs, acc1, ws, wd) : hb1;
      e.a0   = ar ? rdm(1'b0, as, acc0, ws, wd) : ha0;
      e.b0   = br ? rdm(1'b0, bs, acc0, ws, wd) : hb0;
      e.drop = w && mbusy;
      e.busy = mbusy ? (midx != 15) : c;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 16; i++) begin mz[i] = '0; mn[i] = '0; end
      mbusy = 1'b0; midx = 0;
    end else begin
      if (mbusy) begin
        mz[midx] = '0; mn[midx] = '0;
        midx++;
        if (midx == 16) mbusy = 1'b0;
      end else if (c) begin
        mbusy = 1'b1; midx = 0;
      end
      if (acc1) mz[ws] = wd;
      if (acc0) mn[ws] = wd;
    end
    g = sbq.pop_front();
    ha1 = g.a1; hb1 = g.b1; ha0 = g.a0; hb0 = g.b0;
    chk("a_zr", a1, g.a1);
    chk("b_zr", b1, g.b1);
    chk("a_nz", a0, g.a0);
    chk("b_nz", b0, g.b0);
    chk("busy_zr", {31'b0, busy1}, {31'b0, g.busy});
    chk("busy_nz", {31'b0, busy0}, {31'b0, g.busy});
    chk("drop_zr", {31'b0, drop1}, {31'b0, g.drop});
    chk("drop_nz", {31'b0, drop0}, {31'b0, g.drop});
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 1'b1, 4'(15 - i), 1'b0);
  endtask

  initial begin
    mbusy = 1'b0; midx = 0;
    ha1 = '0; hb1 = '0; ha0 = '0; hb0 = '0;
    for (int i = 0; i < 16; i++) begin mz[i] = '0; mn[i] = '0; end

    tbl[0] = '{1'b1, 4'd1, 32'h11111111, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 4'd2, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 1'b1, 4'd2, 32'h11111111, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 4'd0, 32'h12345678, 1'b0, 4'd0, 1'b0, 4'd0, 32'h11111111, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 1'b1, 4'd0, 32'h0, 32'h0};
    tbl[5] = '{1'b1, 4'd5, 32'h01010101, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h0};
    tbl[6] = '{1'b1, 4'd5, 32'hCAFEF00D, 1'b1, 4'd5, 1'b0, 4'd0,
               BYP ? 32'hCAFEF00D : 32'h01010101, 32'h0};
    tbl[7] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0, 4'd0, 32'hCAFEF00D, 32'h0};

    // reset, then every address reads zero
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    read_all();

    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, tbl[i].w, tbl[i].ws, tbl[i].wd, tbl[i].ar, tbl[i].as,
          tbl[i].br, tbl[i].bs, 1'b0);
      chk($sformatf("vec%0d_a", i), a1, tbl[i].ea);
      chk($sformatf("vec%0d_b", i), b1, tbl[i].eb);
      if (i == 4) chk("nz_r0_readback", a0, 32'h12345678);
    end

    // fill all registers; last write shares its cycle with the clear request
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b1, 4'(i), 32'h10000000 + 32'(i), 1'b0, 4'd0, 1'b0, 4'd0, i == 15);
    nbusy = busy1 ? 1 : 0;
    ndrop = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, k == 4, 4'd3, 32'hAAAA5555, k == 2, 4'd15, 1'b0, 4'd0, k == 6);
      if (k == 2) chk("r15_old_during_clear", a1, 32'h1000000F);
      if (busy1) nbusy++;
      if (drop1) ndrop++;
    end
    chk("busy_cycles", 32'(nbusy), 32'd16);
    chk("drop_pulses", 32'(ndrop), 32'd1);
    read_all();
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b1, 4'd15, 1'b0);
    chk("r3_after_clear", a1, 32'h0);
    chk("r15_after_clear", b1, 32'h0);

    // reset in the middle of a clear
    for (int i = 1; i < 16; i++)
      cyc(1'b0, 1'b1, 4'(i), 32'hA5000000 + 32'(i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    idle_cyc();
    idle_cyc();
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    chk("busy_after_rst", {31'b0, busy1}, 32'h0);
    read_all();
    idle_cyc();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
